// File: rtl/dl2_mem_bridge.sv
// DL2 block fill/writeback bridge onto a pipelined req/gnt single-port memory, one subblock per beat.
// Optional feature macro CRITICAL_WORD_FIRST_EN: read beats start at the addressed subblock and wrap.
module dl2_mem_bridge #(
  parameter int ADDR_BITS = 32,
  parameter int SUB_W     = 64,
  parameter int SUB_LOG2  = 2,
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addrD,
  input  logic                 enD,
  input  logic                 weD,
  input  logic [SUB_LOG2-1:0]  doutDstrobe,
  input  logic [SUB_W-1:0]     doutD,
  output logic [SUB_LOG2-1:0]  dinDstrobe,
  output logic [SUB_W-1:0]     dinD,
  output logic                 readyD,
  output logic                 accR,
  output logic                 accW,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [SUB_W-1:0]     mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [SUB_W-1:0]     mem_rdata
);
  localparam int SUBBLOCKS = 1 << SUB_LOG2;
  localparam int BYTE_LOG2 = $clog2(SUB_W / 8);
  localparam int OFF_W     = SUB_LOG2 + BYTE_LOG2;
  localparam int CNT_W     = SUB_LOG2 + 1;
  localparam int OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] SB_CNT  = CNT_W'(SUBBLOCKS);
  localparam logic [CNT_W-1:0] SB_LAST = CNT_W'(SUBBLOCKS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;
  state_t state, state_nxt;

  logic [ADDR_BITS-OFF_W-1:0] base_hi;
  logic [SUB_LOG2-1:0]        crit, crit_in, issue_idx, ret_idx;
  logic [CNT_W-1:0]           issued, returned;
  logic [OUT_W-1:0]           outstanding;
  logic                       fire, rv, rd_go, wr_go;
  logic                       unused_low;

  // Beats never carry out of the block: the index simply replaces the subblock field.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-OFF_W-1:0] hi,
                                                     input logic [SUB_LOG2-1:0] idx);
    return {hi, idx, {BYTE_LOG2{1'b0}}};
  endfunction

`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_in = addrD[OFF_W-1:BYTE_LOG2];
`else
  assign crit_in = '0;
`endif
  assign unused_low = ^addrD[OFF_W-1:0];

  assign fire      = mem_req && mem_gnt;
  assign rv        = (state == RD) && mem_rvalid && (outstanding != '0);
  assign issue_idx = issued[SUB_LOG2-1:0] + crit;
  assign ret_idx   = returned[SUB_LOG2-1:0] + crit;
  assign wr_go     = (state == IDLE) && weD;
  assign rd_go     = (state == IDLE) && !weD && enD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      base_hi     <= '0;
      crit        <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      readyD      <= 1'b0;
      accW        <= 1'b0;
      dinD        <= '0;
      dinDstrobe  <= '0;
    end else begin
      state  <= state_nxt;
      readyD <= 1'b0;
      accW   <= 1'b0;
      if (rd_go || wr_go) begin
        base_hi     <= addrD[ADDR_BITS-1:OFF_W];
        crit        <= crit_in;
        issued      <= '0;
        returned    <= '0;
        outstanding <= '0;
      end
      if (state == RD) begin
        if (fire) issued <= issued + CNT_W'(1);
        if (fire && !rv) outstanding <= outstanding + OUT_W'(1);
        else if (!fire && rv) outstanding <= outstanding - OUT_W'(1);
        if (rv) begin
          returned   <= returned + CNT_W'(1);
          readyD     <= 1'b1;
          dinD       <= mem_rdata;
          dinDstrobe <= ret_idx;
        end
      end
      // The completion pulse coincides with the final accW.
      if (state == WR && fire) begin
        issued <= issued + CNT_W'(1);
        accW   <= 1'b1;
        if (issued == SB_LAST) begin
          readyD     <= 1'b1;
          dinDstrobe <= '0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (weD) state_nxt = WR;
               else if (enD) state_nxt = RD;
      RD:      if (rv && returned == SB_LAST) state_nxt = GAP;
      WR:      if (fire && issued == SB_LAST) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    accR      = 1'b0;
    case (state)
      IDLE: accR = enD && !weD && reset;
      RD: begin
        mem_req  = (issued < SB_CNT) && (outstanding < OUT_MAX);
        mem_addr = beat_addr(base_hi, issue_idx);
      end
      // Holding req low while accW is up gives the requester a cycle to advance doutDstrobe.
      WR: begin
        mem_req   = !accW && (issued < SB_CNT);
        mem_we    = 1'b1;
        mem_addr  = beat_addr(base_hi, doutDstrobe);
        mem_wdata = doutD;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dl2_mem_bridge.sv
// Scoreboard bench for dl2_mem_bridge: a memory model with configurable grant stall and read latency.
module tb_dl2_mem_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addrD;
  logic        enD, weD;
  logic [1:0]  doutDstrobe;
  logic [63:0] doutD;
  logic [1:0]  dinDstrobe;
  logic [63:0] dinD;
  logic        readyD, accR, accW;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  dl2_mem_bridge #(.ADDR_BITS(32), .SUB_W(64), .SUB_LOG2(2), .MAX_OUT(2)) dut (
    .clk(clk), .reset(rst_n), .addrD(addrD), .enD(enD), .weD(weD),
    .doutDstrobe(doutDstrobe), .doutD(doutD), .dinDstrobe(dinDstrobe), .dinD(dinD),
    .readyD(readyD), .accR(accR), .accW(accW), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_data(input logic [31:0] a);
    logic [7:0] b;
    b = {6'b0, a[4:3]} * 8'h11;
    return {a, 24'h0, b};
  endfunction

  logic [31:0] exp_raddr[$];
  logic [65:0] exp_rd[$];
  logic [95:0] exp_wbeat[$];
  typedef struct { int due; logic [63:0] data; } pend_t;
  pend_t pend[$];

  int mem_lat = 1, mem_stall = 0, req_age = 0;
  int tb_out = 0, max_out = 0, wr_hs = 0;
  logic last_we = 1'b0;

  // Memory model and response scoreboard: everything here acts on the falling edge.
  always @(negedge clk) begin
    logic [65:0] er;
    logic [95:0] ew;
    logic [31:0] ea;
    if (rst_n && readyD) begin
      if (!last_we) begin
        check("rd_pending", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          er = exp_rd.pop_front();
          check("rd_strobe", dinDstrobe, er[65:64]);
          check("rd_data", dinD, er[63:0]);
        end
      end else begin
        check("wr_beats_at_ready", wr_hs, 4);
        check("wr_ready_strobe", dinDstrobe, 0);
        wr_hs = 0;
      end
    end
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
      void'(pend.pop_front());
      if (tb_out > 0) tb_out--;
    end
    mem_gnt = (mem_stall == 0) ? 1'b1 : (mem_req && req_age >= mem_stall);
    if (mem_req && mem_gnt) begin
      req_age = 0;
      if (mem_we) begin
        last_we = 1'b1;
        wr_hs++;
        check("wr_pending", exp_wbeat.size() != 0, 1);
        if (exp_wbeat.size() != 0) begin
          ew = exp_wbeat.pop_front();
          check("wr_addr", mem_addr, ew[95:64]);
          check("wr_data", mem_wdata, ew[63:0]);
        end
      end else begin
        last_we = 1'b0;
        tb_out++;
        if (tb_out > max_out) max_out = tb_out;
        check("rd_addr_pending", exp_raddr.size() != 0, 1);
        if (exp_raddr.size() != 0) begin
          ea = exp_raddr.pop_front();
          check("rd_addr", mem_addr, ea);
        end
        pend.push_back('{cyc + mem_lat, rd_data(mem_addr)});
      end
    end else if (mem_req) req_age++;
    else req_age = 0;
  end

  task automatic push_fill(input logic [31:0] a, input int lat, input int stall);
    logic [1:0]  c, idx;
    logic [31:0] ba;
`ifdef CRITICAL_WORD_FIRST_EN
    c = a[4:3];
`else
    c = 2'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      idx = c + 2'(i);
      ba  = {a[31:5], idx, 3'b000};
      exp_raddr.push_back(ba);
      exp_rd.push_back({idx, rd_data(ba)});
    end
    mem_lat = lat; mem_stall = stall; max_out = 0;
  endtask

  task automatic wait_acc(output int c);
    bit seen = 0;
    c = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (accR) begin c = cyc; seen = 1; end
      else begin @(posedge clk); #1; end
    end
    check("accr_seen", seen, 1);
    @(posedge clk); #1;
    enD = 1'b0; #1;
    check("accr_pulse", accR, 0);
  endtask

  task automatic start_fill(input logic [31:0] a, input int lat, input int stall, output int acc);
    push_fill(a, lat, stall);
    addrD = a; enD = 1'b1; #1;
    wait_acc(acc);
  endtask

  task automatic wait_ready(input int n, output int first, output int last);
    int got = 0;
    first = -1; last = -1;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(posedge clk); #1;
      if (readyD) begin
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    check("ready_count", got, n);
  endtask

  int wr_accw, wr_rdy, wr_accr, wr_rdy_cyc;
  task automatic do_write(input logic [31:0] base, input logic [63:0] d0);
    for (int i = 0; i < 4; i++) exp_wbeat.push_back({base + 32'(i * 8), d0 + 64'(i)});
    mem_stall = 0; mem_lat = 1;
    wr_accw = 0; wr_rdy = 0; wr_accr = 0; wr_rdy_cyc = -1;
    addrD = base; weD = 1'b1; doutDstrobe = 2'd0; doutD = d0;
    for (int c = 0; c < 200 && wr_rdy == 0; c++) begin
      @(posedge clk); #1;
      if (accR) wr_accr++;
      if (accW) begin
        wr_accw++;
        doutDstrobe = doutDstrobe + 2'd1;
        doutD = d0 + 64'(wr_accw);
      end
      if (readyD) begin wr_rdy++; wr_rdy_cyc = cyc; weD = 1'b0; end
    end
    check("wr_accw", wr_accw, 4);
    check("wr_ready", wr_rdy, 1);
    check("wr_no_accr", wr_accr, 0);
  endtask

  initial begin
    int acc, f, l, extra;
    rst_n = 1'b0; enD = 1'b1; weD = 1'b0; addrD = 32'h1028; doutD = '0; doutDstrobe = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {dinDstrobe, readyD, accR, accW, mem_req, mem_we, mem_addr}, 0);
    check("rst_data", {dinD, mem_wdata}, 0);
    enD = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait fill
    start_fill(32'h1028, 1, 0, acc);
    wait_ready(4, f, l);
    check("fill_latency", f - acc, 3);
    check("fill_back_to_back", l - f, 3);
    repeat (3) @(posedge clk);
    #1;

    // Critical-word address (order depends on build option)
    start_fill(32'h1030, 1, 0, acc);
    wait_ready(4, f, l);
    check("cwf_back_to_back", l - f, 3);
    repeat (3) @(posedge clk);
    #1;

    // Writeback
    do_write(32'h2000, 64'hA0);
    extra = 0;
    repeat (4) begin @(posedge clk); #1; if (accW || readyD) extra++; end
    check("wr_no_extra", extra, 0);

    // Simultaneous read and write requests: write wins, read stays pending
    push_fill(32'h4008, 1, 0);
    enD = 1'b1;
    do_write(32'h3000, 64'hB0);
    addrD = 32'h4008; #1;
    check("wr_gap_no_acc", accR, 0);
    wait_acc(acc);
    check("wr_turnaround", (acc - wr_rdy_cyc >= 1) && (acc - wr_rdy_cyc <= 2), 1);
    wait_ready(4, f, l);
    repeat (3) @(posedge clk);
    #1;

    // Stalled grants, long latency: outstanding limited to MAX_OUT
    start_fill(32'h6000, 12, 3, acc);
    wait_ready(4, f, l);
    check("max_out", max_out, 2);
    push_fill(32'h5000, 6, 0);
    addrD = 32'h5000; enD = 1'b1; #1;
    check("gap_no_acc", accR, 0);
    wait_acc(acc);
    check("rd_turnaround", acc - l, 1);

    // Reset in the middle of a fill
    wait_ready(2, f, l);
    rst_n = 1'b0; #1;
    check("midrst_ctl", {dinDstrobe, readyD, accR, accW, mem_req, mem_we, mem_addr}, 0);
    check("midrst_data", {dinD, mem_wdata}, 0);
    exp_raddr.delete(); exp_rd.delete(); tb_out = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin @(posedge clk); #1; if (readyD) extra++; end
    check("late_rvalid_ignored", extra, 0);
    check("late_drained", pend.size(), 0);
    start_fill(32'h7010, 1, 0, acc);
    wait_ready(4, f, l);
    check("post_rst_latency", f - acc, 3);
    repeat (3) @(posedge clk);
    #1;
    check("rd_left", exp_rd.size(), 0);
    check("raddr_left", exp_raddr.size(), 0);
    check("wbeat_left", exp_wbeat.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
